uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM state encoding and default bit timing.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  // 115200 baud from a 50 MHz clock
  localparam int unsigned ClkDivDefault = 434;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head and a pop-frees-slot path for push-while-full.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  output logic             wr_ready_o,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             rd_valid_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] mem_q [Depth];
  logic             empty, full, pop, push;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign pop        = rd_en_i & ~empty;
  assign wr_ready_o = ~full | pop;
  assign push       = wr_en_i & wr_ready_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q + (AddrW+1)'(pop);
    wr_ptr_d = wr_ptr_q + (AddrW+1)'(push);
    // Bypass the write when it lands in the slot that becomes the new head
    if (push && (wr_ptr_q[AddrW-1:0] == rd_ptr_d[AddrW-1:0])) begin
      head_d = wr_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d[AddrW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  assign rd_data_o  = head_q;
  assign rd_valid_o = ~empty;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, receive FIFO and sticky error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = ClkDivDefault,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int unsigned TimerW = $clog2(CLK_DIV);
  localparam logic [TimerW-1:0] HalfLoad = TimerW'(CLK_DIV / 2 - 1);
  localparam logic [TimerW-1:0] FullLoad = TimerW'(CLK_DIV - 1);

  uart_state_e       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              sync1_q, sync2_q;
  logic [1:0]        sync_vld_q, sync_vld_d;
  logic              line_hi_q, line_hi_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              rx_s, start_edge, timer_zero;
  logic              push_req, frame_set, overrun_set, fifo_wr_ready;

  assign rx_s       = sync2_q;
  assign timer_zero = (timer_q == '0);
  // line_hi_q only counts highs seen after the synchronizer has flushed its reset value
  assign sync_vld_d = {sync_vld_q[0], 1'b1};
  assign line_hi_d  = sync_vld_q[1] & rx_s;
  assign start_edge = line_hi_q & ~rx_s;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_edge) begin
          timer_d = HalfLoad;
          state_d = StStart;
        end
      end
      StStart: begin
        if (!timer_zero) begin
          timer_d = timer_q - TimerW'(1);
        end else if (!rx_s) begin
          timer_d   = FullLoad;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (!timer_zero) begin
          timer_d = timer_q - TimerW'(1);
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          timer_d = FullLoad;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (!timer_zero) begin
          timer_d = timer_q - TimerW'(1);
        end else begin
          state_d   = StIdle;
          push_req  = rx_s;
          frame_set = ~rx_s;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A set in the same cycle as err_clr wins
  assign overrun_set = push_req & ~fifo_wr_ready;
  assign frame_err_d = frame_set | (frame_err_q & ~err_clr);
  assign overrun_d   = overrun_set | (overrun_q & ~err_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync_vld_q  <= '0;
      line_hi_q   <= 1'b0;
      state_q     <= StIdle;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= ser_rx;
      sync2_q     <= sync1_q;
      sync_vld_q  <= sync_vld_d;
      line_hi_q   <= line_hi_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .wr_en_i    (push_req),
    .wr_data_i  (shift_q),
    .wr_ready_o (fifo_wr_ready),
    .rd_en_i    (rx_ready),
    .rd_data_o  (rx_data),
    .rd_valid_o (rx_valid)
  );

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, directed corner sequences and a randomized queue-model phase.
module tb_uart_rx;

  localparam int CLK_DIV    = 8;
  localparam int FIFO_DEPTH = 4;
  // 2 sync flops + edge detect, half a bit to mid-start, 9 more bit times to mid-stop
  localparam int ValidEdge  = 3 + CLK_DIV / 2 + 9 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       ser_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_ov;
    logic       pop_after;
    logic       clr_after;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ser_rx    (ser_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one 8N1 frame; optionally pulses rx_ready/err_clr in the stop-sample cycle.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic pop_at_stop,
                            input logic clr_at_stop, output int valid_edge);
    logic [9:0] bits;
    logic       was_valid;
    int         n;
    bits       = {stop, data, 1'b0};
    was_valid  = rx_valid;
    valid_edge = -1;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        n        = b * CLK_DIV + c;
        ser_rx   = bits[0];
        rx_ready = pop_at_stop && (n == ValidEdge - 1);
        err_clr  = clr_at_stop && (n == ValidEdge - 1);
        tick();
        if (valid_edge < 0 && !was_valid && rx_valid) valid_edge = n + 1;
      end
      bits = bits >> 1;
    end
    ser_rx   = 1'b1;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ve;
    logic [7:0] d;
    logic       stop_b;
    int         npops;
    logic [9:0] bits;
    logic [7:0] q[$];
    logic       m_fe, m_ov;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h02, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h03, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h04, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h05, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};

    reset    = 1'b1;
    ser_rx   = 1'b1;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    tick();
    tick();
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ov", overrun, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_valid", rx_valid, 0);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, 1'b0, 1'b0, ve);
      if (i == 0) chk("valid_latency", ve, ValidEdge);
      chk($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_fe", i), frame_err, vecs[i].exp_fe);
      chk($sformatf("vec%0d_ov", i), overrun, vecs[i].exp_ov);
      if (vecs[i].pop_after) pop_one();
      if (vecs[i].clr_after) begin
        clear_err();
        chk($sformatf("vec%0d_fe_clr", i), frame_err, 0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), rx_valid, 1);
      chk($sformatf("drain%0d_data", i), rx_data, i + 1);
      pop_one();
    end
    chk("drain_empty", rx_valid, 0);
    clear_err();
    chk("ov_clr", overrun, 0);

    // Short low glitch must be rejected and leave the FSM idle
    ser_rx = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    ser_rx = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_fe", frame_err, 0);
    chk("glitch_ov", overrun, 0);
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, ve);
    chk("after_glitch_valid", rx_valid, 1);
    chk("after_glitch_data", rx_data, 8'h96);
    pop_one();

    // err_clr coinciding with a frame error: set wins
    send_frame(8'h77, 1'b0, 1'b0, 1'b1, ve);
    chk("clr_vs_set_fe", frame_err, 1);
    clear_err();
    chk("clr_vs_set_fe_after", frame_err, 0);

    // Push on a full FIFO with a pop in the same cycle
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 1'b0, 1'b0, ve);
    send_frame(8'h15, 1'b1, 1'b1, 1'b0, ve);
    chk("full_pushpop_ov", overrun, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_pushpop%0d_data", i), rx_data, 8'h12 + 8'(i));
      pop_one();
    end
    chk("full_pushpop_empty", rx_valid, 0);

    // Reset in the middle of DATA bit 4 with state dirty
    send_frame(8'h42, 1'b1, 1'b0, 1'b0, ve);
    send_frame(8'h24, 1'b0, 1'b0, 1'b0, ve);
    bits = {1'b1, 8'h6B, 1'b0};
    for (int n = 0; n < 5 * CLK_DIV + 3; n++) begin
      ser_rx = bits[0];
      tick();
      if ((n + 1) % CLK_DIV == 0) bits = bits >> 1;
    end
    ser_rx = 1'b0;
    reset  = 1'b1;
    #2;
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_data", rx_data, 0);
    chk("midrst_fe", frame_err, 0);
    chk("midrst_ov", overrun, 0);
    tick();
    tick();
    reset = 1'b0;
    // Line held low across reset release is not a start bit
    for (int i = 0; i < 30; i++) tick();
    ser_rx = 1'b1;
    for (int i = 0; i < 12 * CLK_DIV; i++) tick();
    chk("low_after_rst_valid", rx_valid, 0);
    chk("low_after_rst_fe", frame_err, 0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, ve);
    chk("after_rst_valid", rx_valid, 1);
    chk("after_rst_data", rx_data, 8'h5A);
    chk("after_rst_fe", frame_err, 0);
    chk("after_rst_ov", overrun, 0);
    pop_one();

    // Randomized frames against a queue model
    m_fe = 1'b0;
    m_ov = 1'b0;
    for (int k = 0; k < 25; k++) begin
      d      = 8'($urandom_range(0, 255));
      stop_b = ($urandom_range(0, 5) != 0);
      send_frame(d, stop_b, 1'b0, 1'b0, ve);
      if (stop_b) begin
        if (q.size() < FIFO_DEPTH) q.push_back(d);
        else m_ov = 1'b1;
      end else begin
        m_fe = 1'b1;
      end
      chk($sformatf("rnd%0d_valid", k), rx_valid, (q.size() != 0));
      if (q.size() != 0) chk($sformatf("rnd%0d_data", k), rx_data, q[0]);
      chk($sformatf("rnd%0d_fe", k), frame_err, m_fe);
      chk($sformatf("rnd%0d_ov", k), overrun, m_ov);
      npops = $urandom_range(0, 3);
      for (int p = 0; p < npops; p++) begin
        if (q.size() != 0) chk($sformatf("rnd%0d_pop%0d", k, p), rx_data, q[0]);
        pop_one();
        if (q.size() != 0) void'(q.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        clear_err();
        m_fe = 1'b0;
        m_ov = 1'b0;
      end
    end
    chk("rnd_final_valid", rx_valid, (q.size() != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
